// File: rtl/clk_detect_pkg.sv
// Shared types, default sizes and helpers for the multi-channel clock presence monitor.
package clk_detect_pkg;

    localparam int unsigned DEF_N_CH       = 4;
    localparam int unsigned DEF_FREQ_CNT_W = 12;

    typedef enum logic [1:0] {
        ABSENT  = 2'd0,
        QUALIFY = 2'd1,
        PRESENT = 2'd2
    } clk_det_state_t;

    // Bits needed to hold the values 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/clk_detect_mc_if.sv
// Toggle inputs, frequency bounds and status outputs of the clock presence monitor.
interface clk_detect_mc_if
    import clk_detect_pkg::*;
#(
    parameter int unsigned N_CH       = DEF_N_CH,
    parameter int unsigned FREQ_CNT_W = DEF_FREQ_CNT_W
);
    logic [N_CH-1:0]            obs_toggle_i;
    logic [FREQ_CNT_W-1:0]      freq_min_i;
    logic [FREQ_CNT_W-1:0]      freq_max_i;
    logic [N_CH-1:0]            clk_present_o;
    logic [N_CH-1:0]            present_rise_o;
    logic [N_CH-1:0]            present_fall_o;
    logic [N_CH*FREQ_CNT_W-1:0] freq_cnt_o;
    logic [N_CH-1:0]            freq_ok_o;
    logic                       freq_valid_o;

    modport master (
        output obs_toggle_i, freq_min_i, freq_max_i,
        input  clk_present_o, present_rise_o, present_fall_o,
               freq_cnt_o, freq_ok_o, freq_valid_o
    );

    modport slave (
        input  obs_toggle_i, freq_min_i, freq_max_i,
        output clk_present_o, present_rise_o, present_fall_o,
               freq_cnt_o, freq_ok_o, freq_valid_o
    );
endinterface

// File: rtl/clk_detect_ch.sv
// One monitored channel: toggle synchroniser, edge strobe, absence watchdog,
// presence qualification FSM and registered present/rise/fall outputs.
module clk_detect_ch
    import clk_detect_pkg::*;
#(
    parameter int unsigned ABSENCE_TICKS  = 10,
    parameter int unsigned PRESENCE_EDGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic toggle,
    output logic present,
    output logic rise,
    output logic fall,
    output logic edge_c
);
    localparam int unsigned AW = cnt_w(ABSENCE_TICKS);
    localparam int unsigned EW = cnt_w(PRESENCE_EDGES);

    logic [2:0]     sync_q;
    logic [AW-1:0]  abs_q;
    logic           timeout_c;
    clk_det_state_t state_q, state_d;
    logic [EW-1:0]  edge_cnt_q, edge_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], toggle};
    end

    assign edge_c    = sync_q[1] ^ sync_q[2];
    assign timeout_c = (abs_q == AW'(ABSENCE_TICKS));

    // Watchdog: an edge always clears, so an edge coinciding with timeout wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             abs_q <= '0;
        else if (edge_c)     abs_q <= '0;
        else if (!timeout_c) abs_q <= abs_q + AW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ABSENT;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        unique case (state_q)
            ABSENT: begin
                if (edge_c) begin
                    if (PRESENCE_EDGES <= 1) begin
                        state_d    = PRESENT;
                        edge_cnt_d = '0;
                    end else begin
                        state_d    = QUALIFY;
                        edge_cnt_d = EW'(1);
                    end
                end
            end
            QUALIFY: begin
                if (edge_c) begin
                    if (edge_cnt_q + EW'(1) >= EW'(PRESENCE_EDGES)) begin
                        state_d    = PRESENT;
                        edge_cnt_d = '0;
                    end else begin
                        edge_cnt_d = edge_cnt_q + EW'(1);
                    end
                end else if (timeout_c) begin
                    state_d    = ABSENT;
                    edge_cnt_d = '0;
                end
            end
            PRESENT: begin
                if (!edge_c && timeout_c) state_d = ABSENT;
            end
            default: begin
                state_d    = ABSENT;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            present <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            present <= (state_q == PRESENT);
            rise    <= (state_q == PRESENT) && !present;
            fall    <= (state_q != PRESENT) && present;
        end
    end

endmodule

// File: rtl/clk_detect_mc.sv
// Multi-channel clock presence monitor; define CLK_DETECT_FREQ_MEAS_EN to build the
// per-window edge counting and frequency window check.
module clk_detect_mc
    import clk_detect_pkg::*;
#(
    parameter int unsigned N_CH           = DEF_N_CH,
    parameter int unsigned ABSENCE_TICKS  = 10,
    parameter int unsigned PRESENCE_EDGES = 3,
    parameter int unsigned WINDOW_TICKS   = 1024,
    parameter int unsigned FREQ_CNT_W     = DEF_FREQ_CNT_W
) (
    input  logic           ref_clk_i,
    input  logic           rst_i,
    clk_detect_mc_if.slave bus
);
    logic [N_CH-1:0] edge_s;
    logic [N_CH-1:0] present_s;
    logic [N_CH-1:0] rise_s;
    logic [N_CH-1:0] fall_s;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        clk_detect_ch #(
            .ABSENCE_TICKS (ABSENCE_TICKS),
            .PRESENCE_EDGES(PRESENCE_EDGES)
        ) u_ch (
            .clk    (ref_clk_i),
            .rst    (rst_i),
            .toggle (bus.obs_toggle_i[c]),
            .present(present_s[c]),
            .rise   (rise_s[c]),
            .fall   (fall_s[c]),
            .edge_c (edge_s[c])
        );
    end

    assign bus.clk_present_o  = present_s;
    assign bus.present_rise_o = rise_s;
    assign bus.present_fall_o = fall_s;

`ifdef CLK_DETECT_FREQ_MEAS_EN
    localparam int unsigned WW = cnt_w(WINDOW_TICKS - 1);
    localparam logic [FREQ_CNT_W-1:0] CNT_MAX = '1;

    logic [WW-1:0] win_q;
    logic          wrap_c;
    logic          valid_q;

    assign wrap_c = (win_q == WW'(WINDOW_TICKS - 1));

    always_ff @(posedge ref_clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            win_q   <= wrap_c ? '0 : win_q + WW'(1);
            valid_q <= wrap_c;
        end
    end

    // Per-channel saturating edge count; an edge on the wrap cycle opens the next window.
    for (genvar c = 0; c < N_CH; c++) begin : g_freq
        logic [FREQ_CNT_W-1:0] cnt_q;
        logic [FREQ_CNT_W-1:0] lat_q;
        logic                  ok_q;

        always_ff @(posedge ref_clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
                lat_q <= '0;
                ok_q  <= 1'b0;
            end else if (wrap_c) begin
                lat_q <= cnt_q;
                ok_q  <= (cnt_q >= bus.freq_min_i) && (cnt_q <= bus.freq_max_i);
                cnt_q <= edge_s[c] ? FREQ_CNT_W'(1) : '0;
            end else if (edge_s[c] && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + FREQ_CNT_W'(1);
            end
        end

        assign bus.freq_cnt_o[c*FREQ_CNT_W +: FREQ_CNT_W] = lat_q;
        assign bus.freq_ok_o[c]                          = ok_q;
    end

    assign bus.freq_valid_o = valid_q;
`else
    localparam int unsigned unused_freq_cfg = WINDOW_TICKS + FREQ_CNT_W;
    logic unused_freq_in;

    assign unused_freq_in   = ^{edge_s, bus.freq_min_i, bus.freq_max_i};
    assign bus.freq_cnt_o   = '0;
    assign bus.freq_ok_o    = '0;
    assign bus.freq_valid_o = 1'b0;
`endif

endmodule
